// File: rtl/evr_event_injector.sv
// evr_event_injector: merges software-queued event codes into idle slots of the
// upstream event stream. Each queued entry is {code[7:0], delay[15:0]}. Code 0
// marks a delay-only entry. Upstream events always win the slot.
module evr_event_injector #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DEFER_WIDTH = 16
) (
    input  logic                   evrClk,
    input  logic                   evrReset_n,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   wrValid,
    output logic                   wrReady,
    input  logic [7:0]             wrCode,
    input  logic [15:0]            wrDelay,
    input  logic [7:0]             upCode,
    input  logic                   upCodeValid,
    output logic [7:0]             evCode,
    output logic                   evCodeValid,
    output logic [ADDR_WIDTH:0]    fifoCount,
    output logic                   busy,
    output logic [DEFER_WIDTH-1:0] deferCount,
    output logic [15:0]            injectCount
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [15:0]            counter_q, counter_d;
    logic [7:0]             code_q, code_d;
    logic [7:0]             ev_code_q, ev_code_d;
    logic                   ev_valid_q, ev_valid_d;
    logic [DEFER_WIDTH-1:0] defer_q, defer_d;
    logic [15:0]            inject_q, inject_d;

    logic [23:0] mem [DEPTH];
    logic [23:0] head;
    logic        full;
    logic        empty;
    logic        wr_en;
    logic        pop;
    logic        inject;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign wrReady = !full && !flush;
    assign wr_en   = wrValid && wrReady;
    assign head    = mem[rd_ptr_q];
    assign pop     = (state_q == IDLE) && !empty && enable && !flush;
    assign inject  = (state_q == SEND) && (code_q != 8'd0) && enable
                     && !upCodeValid && !flush;

    // Queue storage: written on accepted writes, intentionally not reset.
    always_ff @(posedge evrClk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {wrCode, wrDelay};
        end
    end

    // Queue pointers and occupancy; flush empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !wr_en) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Next-state logic for IDLE -> WAIT -> SEND plus deferral/injection counters.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        code_d    = code_q;
        defer_d   = defer_q;
        inject_d  = inject_q;
        if (flush) begin
            state_d   = IDLE;
            counter_d = '0;
            code_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        counter_d = head[15:0];
                        code_d    = head[23:16];
                        state_d   = WAIT;
                    end
                end
                WAIT: begin
                    if (enable) begin
                        if (counter_q == '0) begin
                            state_d = SEND;
                        end else begin
                            counter_d = counter_q - 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (code_q == 8'd0) begin
                        state_d = IDLE;
                    end else if (enable) begin
                        if (upCodeValid) begin
                            if (defer_q != '1) begin
                                defer_d = defer_q + 1'b1;
                            end
                        end else begin
                            inject_d = inject_q + 1'b1;
                            state_d  = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output mux: upstream has priority, then an injected code, else an empty slot.
    always_comb begin
        ev_code_d  = '0;
        ev_valid_d = 1'b0;
        if (upCodeValid) begin
            ev_code_d  = upCode;
            ev_valid_d = 1'b1;
        end else if (inject) begin
            ev_code_d  = code_q;
            ev_valid_d = 1'b1;
        end
    end

    // State register; reset clears everything including the output slot.
    always_ff @(posedge evrClk or negedge evrReset_n) begin
        if (!evrReset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            counter_q  <= '0;
            code_q     <= '0;
            ev_code_q  <= '0;
            ev_valid_q <= 1'b0;
            defer_q    <= '0;
            inject_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            counter_q  <= counter_d;
            code_q     <= code_d;
            ev_code_q  <= ev_code_d;
            ev_valid_q <= ev_valid_d;
            defer_q    <= defer_d;
            inject_q   <= inject_d;
        end
    end

    assign evCode      = ev_code_q;
    assign evCodeValid = ev_valid_q;
    assign fifoCount   = count_q;
    assign busy        = (state_q != IDLE);
    assign deferCount  = defer_q;
    assign injectCount = inject_q;

endmodule

// File: tb/tb_evr_event_injector.sv
// Bench for evr_event_injector: a queue-based reference model predicts every
// output slot and counter; each scenario task checks the DUT against it.
module tb_evr_event_injector;

    logic        evrClk = 1'b0;
    logic        evrReset_n;
    logic        enable;
    logic        flush;
    logic        wrValid;
    logic        wrReady;
    logic [7:0]  wrCode;
    logic [15:0] wrDelay;
    logic [7:0]  upCode;
    logic        upCodeValid;
    logic [7:0]  evCode;
    logic        evCodeValid;
    logic [5:0]  fifoCount;
    logic        busy;
    logic [15:0] deferCount;
    logic [15:0] injectCount;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: pending entries, the one entry in progress and the
    // number of enabled ticks left before its send decision.
    logic [23:0] mq[$];
    bit          m_cur;
    int          m_ticks;
    logic [7:0]  m_codeq;
    logic [7:0]  m_ev;
    bit          m_evv;
    logic [15:0] m_defer;
    logic [15:0] m_inject;

    evr_event_injector #(.ADDR_WIDTH(5), .DEFER_WIDTH(16)) dut (
        .evrClk(evrClk), .evrReset_n(evrReset_n), .enable(enable), .flush(flush),
        .wrValid(wrValid), .wrReady(wrReady), .wrCode(wrCode), .wrDelay(wrDelay),
        .upCode(upCode), .upCodeValid(upCodeValid), .evCode(evCode),
        .evCodeValid(evCodeValid), .fifoCount(fifoCount), .busy(busy),
        .deferCount(deferCount), .injectCount(injectCount)
    );

    always #5 evrClk = ~evrClk;

    task automatic model_reset();
        mq.delete();
        m_cur = 0; m_ticks = 0; m_codeq = 8'd0;
        m_ev = 8'd0; m_evv = 0; m_defer = 16'd0; m_inject = 16'd0;
    endtask

    task automatic model_edge();
        logic [7:0]  nev;
        bit          nv;
        bit          pushok;
        logic [23:0] e;
        nev = 8'd0; nv = 0;
        if (upCodeValid) begin
            nev = upCode; nv = 1;
        end else if (m_cur && m_ticks == 0 && m_codeq != 8'd0 && enable && !flush) begin
            nev = m_codeq; nv = 1;
        end
        if (flush) begin
            mq.delete();
            m_cur = 0;
        end else begin
            pushok = wrValid && (mq.size() < 32);
            if (m_cur) begin
                if (m_ticks > 0) begin
                    if (enable) m_ticks--;
                end else if (m_codeq == 8'd0) begin
                    m_cur = 0;
                end else if (enable && !upCodeValid) begin
                    m_cur = 0;
                    m_inject = m_inject + 16'd1;
                end else if (enable) begin
                    if (m_defer != 16'hFFFF) m_defer = m_defer + 16'd1;
                end
            end else if (enable && mq.size() > 0) begin
                e = mq.pop_front();
                m_cur = 1;
                m_codeq = e[23:16];
                m_ticks = int'(e[15:0]) + 1;
            end
            if (pushok) mq.push_back({wrCode, wrDelay});
        end
        m_ev = nev; m_evv = nv;
    endtask

    task automatic step();
        model_edge();
        @(posedge evrClk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        enable = 1'b0; flush = 1'b0; wrValid = 1'b0; wrCode = 8'd0;
        wrDelay = 16'd0; upCode = 8'd0; upCodeValid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        evrReset_n = 1'b0;
        model_reset();
        #20;
        evrReset_n = 1'b1;
        #10;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (evCode !== 8'd0) begin errors++; $display("FAIL reset_evCode got %h exp 00", evCode); end
        checks++; if (evCodeValid !== 1'b0) begin errors++; $display("FAIL reset_evValid got %b exp 0", evCodeValid); end
        checks++; if (fifoCount !== 6'd0) begin errors++; $display("FAIL reset_fifoCount got %0d exp 0", fifoCount); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (wrReady !== 1'b1) begin errors++; $display("FAIL reset_wrReady got %b exp 1", wrReady); end
        checks++; if ({deferCount, injectCount} !== 32'd0) begin errors++; $display("FAIL reset_counters got %h/%h exp 0/0", deferCount, injectCount); end
    endtask

    task automatic test_single();
        int w, seen;
        do_reset();
        enable = 1'b1;
        wrValid = 1'b1; wrCode = 8'h7A; wrDelay = 16'd3;
        step();
        w = cyc;
        wrValid = 1'b0;
        checks++; if (fifoCount !== 6'd1) begin errors++; $display("FAIL single_fifo1 got %0d exp 1", fifoCount); end
        seen = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (evCode !== m_ev || evCodeValid !== m_evv) begin
                errors++; $display("FAIL single_ev cyc=%0d got %h/%b exp %h/%b", cyc, evCode, evCodeValid, m_ev, m_evv);
            end
            if (evCodeValid === 1'b1 && evCode === 8'h7A && seen < 0) seen = cyc;
        end
        checks++; if (seen - (w + 1) != 5) begin errors++; $display("FAIL single_latency got %0d exp 5", seen - (w + 1)); end
        checks++; if (injectCount !== 16'd1) begin errors++; $display("FAIL single_inject got %0d exp 1", injectCount); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy); end
    endtask

    task automatic test_defer();
        do_reset();
        enable = 1'b1;
        wrValid = 1'b1; wrCode = 8'h22; wrDelay = 16'd0;
        step();
        wrValid = 1'b0;
        step();
        step();
        upCodeValid = 1'b1; upCode = 8'h01;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (evCode !== 8'h01 || evCodeValid !== 1'b1 || m_ev !== 8'h01) begin
                errors++; $display("FAIL defer_pass cyc=%0d got %h/%b exp 01/1", cyc, evCode, evCodeValid);
            end
        end
        upCodeValid = 1'b0; upCode = 8'h00;
        step();
        checks++; if (evCode !== 8'h22 || evCodeValid !== 1'b1) begin errors++; $display("FAIL defer_inject got %h/%b exp 22/1", evCode, evCodeValid); end
        checks++; if (deferCount !== 16'd4 || deferCount !== m_defer) begin errors++; $display("FAIL defer_count got %0d exp 4", deferCount); end
        checks++; if (injectCount !== 16'd1) begin errors++; $display("FAIL defer_inject_count got %0d exp 1", injectCount); end
    endtask

    task automatic test_full();
        logic [7:0] expq[$];
        logic [7:0] got[$];
        int last, gap_bad, order_bad;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            wrValid = 1'b1; wrCode = 8'($urandom_range(1, 255)); wrDelay = 16'd0;
            expq.push_back(wrCode);
            step();
        end
        wrCode = 8'hEE;
        checks++; if (fifoCount !== 6'd32) begin errors++; $display("FAIL full_count got %0d exp 32", fifoCount); end
        checks++; if (wrReady !== 1'b0) begin errors++; $display("FAIL full_wrReady got %b exp 0", wrReady); end
        step();
        wrValid = 1'b0;
        checks++; if (fifoCount !== 6'd32) begin errors++; $display("FAIL full_held got %0d exp 32", fifoCount); end
        enable = 1'b1;
        step();
        checks++; if (wrReady !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", wrReady); end
        last = -1; gap_bad = 0;
        for (int i = 0; i < 32 * 3 + 20; i++) begin
            step();
            checks++;
            if (evCode !== m_ev || evCodeValid !== m_evv) begin
                errors++; $display("FAIL full_ev cyc=%0d got %h/%b exp %h/%b", cyc, evCode, evCodeValid, m_ev, m_evv);
            end
            if (evCodeValid === 1'b1) begin
                got.push_back(evCode);
                if (last >= 0 && cyc - last != 3) gap_bad++;
                last = cyc;
            end
        end
        checks++; if (got.size() != 32) begin errors++; $display("FAIL full_emitted got %0d exp 32", got.size()); end
        order_bad = 0;
        for (int i = 0; i < 32; i++) if (i >= got.size() || got[i] !== expq[i]) order_bad++;
        checks++; if (order_bad != 0) begin errors++; $display("FAIL full_order got %0d bad exp 0", order_bad); end
        checks++; if (gap_bad != 0) begin errors++; $display("FAIL full_spacing got %0d bad gaps exp 0", gap_bad); end
    endtask

    task automatic test_delay_only();
        int p, seen, nvalid;
        do_reset();
        enable = 1'b1;
        wrValid = 1'b1; wrCode = 8'h00; wrDelay = 16'd10;
        step();
        wrCode = 8'h55; wrDelay = 16'd0;
        step();
        p = cyc;
        wrValid = 1'b0;
        seen = -1; nvalid = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            checks++;
            if (evCode !== m_ev || evCodeValid !== m_evv) begin
                errors++; $display("FAIL delay_ev cyc=%0d got %h/%b exp %h/%b", cyc, evCode, evCodeValid, m_ev, m_evv);
            end
            if (evCodeValid === 1'b1) begin
                nvalid++;
                if (evCode === 8'h55 && seen < 0) seen = cyc;
            end
        end
        checks++; if (seen - p != 15) begin errors++; $display("FAIL delay_latency got %0d exp 15", seen - p); end
        checks++; if (nvalid != 1) begin errors++; $display("FAIL delay_nevents got %0d exp 1", nvalid); end
        checks++; if (injectCount !== 16'd1) begin errors++; $display("FAIL delay_inject got %0d exp 1", injectCount); end
    endtask

    task automatic test_flush();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wrValid = 1'b1; wrCode = 8'($urandom_range(1, 255)); wrDelay = 16'd40;
            upCodeValid = 1'($urandom_range(0, 1)); upCode = 8'($urandom);
            step();
        end
        checks++; if (fifoCount !== 6'd5 || busy !== 1'b1) begin errors++; $display("FAIL flush_pre got %0d/%b exp 5/1", fifoCount, busy); end
        flush = 1'b1; wrCode = 8'h99;
        #1;
        checks++; if (wrReady !== 1'b0) begin errors++; $display("FAIL flush_wrReady got %b exp 0", wrReady); end
        step();
        flush = 1'b0; wrValid = 1'b0;
        checks++; if (evCode !== m_ev || evCodeValid !== m_evv) begin errors++; $display("FAIL flush_pass got %h/%b exp %h/%b", evCode, evCodeValid, m_ev, m_evv); end
        checks++; if (fifoCount !== 6'd0 || busy !== 1'b0) begin errors++; $display("FAIL flush_state got %0d/%b exp 0/0", fifoCount, busy); end
        for (int i = 0; i < 60; i++) begin
            upCodeValid = 1'($urandom_range(0, 1)); upCode = 8'($urandom);
            step();
            checks++;
            if (evCode !== m_ev || evCodeValid !== m_evv || (evCodeValid === 1'b1 && m_ev === 8'h99)) begin
                errors++; $display("FAIL flush_ev cyc=%0d got %h/%b exp %h/%b", cyc, evCode, evCodeValid, m_ev, m_evv);
            end
        end
        checks++; if (injectCount !== 16'd0 || fifoCount !== 6'd0) begin errors++; $display("FAIL flush_after got %0d/%0d exp 0/0", injectCount, fifoCount); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            enable      = ($urandom_range(0, 7) != 0);
            flush       = ($urandom_range(0, 96) == 0);
            wrValid     = ($urandom_range(0, 2) == 0);
            wrCode      = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            wrDelay     = 16'($urandom_range(0, 6));
            upCodeValid = ($urandom_range(0, 3) == 0);
            upCode      = 8'($urandom);
            step();
            checks++;
            if (evCode !== m_ev || evCodeValid !== m_evv) begin
                errors++; $display("FAIL rand_ev cyc=%0d got %h/%b exp %h/%b", cyc, evCode, evCodeValid, m_ev, m_evv);
            end
            checks++;
            if (fifoCount !== 6'(mq.size()) || busy !== 1'(m_cur) || wrReady !== 1'(mq.size() != 32 && !flush)
                || deferCount !== m_defer || injectCount !== m_inject) begin
                errors++; $display("FAIL rand_status cyc=%0d got cnt=%0d busy=%b rdy=%b def=%0d inj=%0d exp cnt=%0d busy=%b def=%0d inj=%0d",
                                   cyc, fifoCount, busy, wrReady, deferCount, injectCount, mq.size(), m_cur, m_defer, m_inject);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        upCodeValid = 1'b1; upCode = 8'h33;
        wrValid = 1'b1; wrCode = 8'hAB; wrDelay = 16'd1;
        step();
        wrValid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (busy !== 1'b1 || evCodeValid !== 1'b1 || deferCount === 16'd0) begin errors++; $display("FAIL areset_pre got busy=%b v=%b def=%0d exp 1/1/>0", busy, evCodeValid, deferCount); end
        #4;
        evrReset_n = 1'b0;
        #1;
        checks++; if (evCodeValid !== 1'b0 || evCode !== 8'd0) begin errors++; $display("FAIL areset_ev got %h/%b exp 00/0", evCode, evCodeValid); end
        checks++; if (busy !== 1'b0 || fifoCount !== 6'd0 || deferCount !== 16'd0 || injectCount !== 16'd0) begin
            errors++; $display("FAIL areset_state got busy=%b cnt=%0d def=%0d inj=%0d exp 0", busy, fifoCount, deferCount, injectCount);
        end
        model_reset();
        upCodeValid = 1'b0;
        #15;
        evrReset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (evCodeValid !== 1'b0 || wrReady !== 1'b1 || m_evv) begin
                errors++; $display("FAIL areset_after cyc=%0d got v=%b rdy=%b exp 0/1", cyc, evCodeValid, wrReady);
            end
        end
    endtask

    initial begin
        idle_inputs();
        evrReset_n = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_defer();
        test_full();
        test_delay_only();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
